// File: rtl/capture_pkg.sv
// Shared types and constants for the capture FIFO readout path.
// The state enum is also meant for the capture controller.
package capture_pkg;

  localparam int CSUM_W = 8;
  localparam int CNT_W  = 16;

  localparam logic [7:0] HDR_BYTE0 = 8'hAA;
  localparam logic [7:0] HDR_BYTE1 = 8'h55;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_LEN_H,
    ST_LEN_L,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_CSUM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector: one register of delay plus AND-NOT.
// RST_VAL=1 makes a level that is already high at reset release look old.
module rise_edge #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_dly;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dly <= RST_VAL;
    end else begin
      r_dly <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_dly;

endmodule

// File: rtl/capture_readout.sv
// Drains one completed capture from the sample FIFO and sends it as a framed
// packet: two header bytes, 16-bit sample count, samples, 8-bit sum of samples.
module capture_readout
  import capture_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 1024,
  parameter logic [7:0]  HDR0      = HDR_BYTE0,
  parameter logic [7:0]  HDR1      = HDR_BYTE1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_fifo_dout,
  input  logic       i_fifo_empty,
  input  logic       i_fifo_full,
  output logic       o_fifo_rd_en,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam logic [CNT_W-1:0] FRAME_LEN_W = CNT_W'(FRAME_LEN);

  state_t             r_state;
  logic [CNT_W-1:0]   r_sample_cnt;
  logic [CSUM_W-1:0]  r_csum;
  logic [7:0]         r_tx_data;
  logic               r_tx_valid;
  logic               r_busy;
  logic               r_frame_done;

  logic w_full_rise;
  logic w_accept;
  logic w_rd_en;
  logic w_last;

  rise_edge #(
    .RST_VAL (1'b1)
  ) u_full_rise (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_fifo_full),
    .o_rise  (w_full_rise)
  );

  assign w_accept = r_tx_valid & i_tx_ready;
  // Read strobe comes straight from FETCH so the data lands during LATCH.
  assign w_rd_en  = (r_state == ST_FETCH) & ~i_fifo_empty;
  assign w_last   = (r_sample_cnt == FRAME_LEN_W);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_sample_cnt <= '0;
      r_csum       <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_full_rise) begin
            r_state    <= ST_HDR0;
            r_tx_data  <= HDR0;
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_HDR0: begin
          if (w_accept) begin
            r_state   <= ST_HDR1;
            r_tx_data <= HDR1;
          end
        end
        ST_HDR1: begin
          if (w_accept) begin
            r_state   <= ST_LEN_H;
            r_tx_data <= FRAME_LEN_W[15:8];
          end
        end
        ST_LEN_H: begin
          if (w_accept) begin
            r_state   <= ST_LEN_L;
            r_tx_data <= FRAME_LEN_W[7:0];
          end
        end
        ST_LEN_L: begin
          if (w_accept) begin
            r_state    <= ST_FETCH;
            r_tx_valid <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (!i_fifo_empty) begin
            r_state <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          r_state      <= ST_SEND;
          r_tx_data    <= i_fifo_dout;
          r_tx_valid   <= 1'b1;
          r_csum       <= r_csum + i_fifo_dout;
          r_sample_cnt <= r_sample_cnt + CNT_W'(1);
        end
        ST_SEND: begin
          if (w_accept) begin
            if (w_last) begin
              r_state   <= ST_CSUM;
              r_tx_data <= r_csum;
            end else begin
              r_state    <= ST_FETCH;
              r_tx_valid <= 1'b0;
            end
          end
        end
        ST_CSUM: begin
          if (w_accept) begin
            r_state      <= ST_DONE;
            r_tx_valid   <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_sample_cnt <= '0;
          r_csum       <= '0;
          r_busy       <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_fifo_rd_en = w_rd_en;
  assign o_tx_data    = r_tx_data;
  assign o_tx_valid   = r_tx_valid;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_capture_readout.sv
// Bench for capture_readout: FIFO model, randomized stimulus and a
// frame-level reference model checked every cycle.
module tb_capture_readout;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_full = 1'b0;
  logic       tx_ready = 1'b0;
  logic       fifo_rd_en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       frame_done;

  capture_readout #(
    .FRAME_LEN (L),
    .HDR0      (8'hAA),
    .HDR1      (8'h55)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_fifo_dout  (fifo_dout),
    .i_fifo_empty (fifo_empty),
    .i_fifo_full  (fifo_full),
    .o_fifo_rd_en (fifo_rd_en),
    .o_tx_data    (tx_data),
    .o_tx_valid   (tx_valid),
    .i_tx_ready   (tx_ready),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  byte unsigned fifo_q[$];
  byte unsigned mdl_q[$];
  byte unsigned log_q[$];
  int  done_cnt = 0;
  int  busy_cycles = 0;
  bit  rand_ready = 1'b0;
  bit  ready_fixed = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model: data valid the cycle after the read strobe
  bit fifo_rd_s;
  initial begin
    forever begin
      @(negedge clk);
      fifo_rd_s = fifo_rd_en;
      @(posedge clk);
      #1;
      if (fifo_rd_s && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // ---------------- Transmitter ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // ---------------- Frame-level reference model and per-cycle compare
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  bit           m_full_prev = 1'b1;
  bit           m_next_done;
  int           m_idx = 0;
  byte unsigned m_csum = 8'h00;
  byte unsigned m_exp;
  bit           p_v = 1'b0;
  bit           p_r = 1'b0;
  bit           p_rd = 1'b0;
  byte unsigned p_d = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 1'b0; m_done = 1'b0; m_full_prev = 1'b1;
        m_idx = 0; m_csum = 8'h00; p_v = 1'b0; p_r = 1'b0; p_rd = 1'b0;
      end else begin
        m_next_done = 1'b0;
        if (busy) busy_cycles++;
        check("busy", int'(busy), int'(m_busy));
        check("frame_done", int'(frame_done), int'(m_done));
        if (!m_busy || m_done) check("valid_idle", int'(tx_valid), 0);
        if (!m_busy) check("rd_idle", int'(fifo_rd_en), 0);
        if (m_busy && !m_done && m_idx < 4) check("hdr_valid", int'(tx_valid), 1);
        if (p_v && !p_r) begin
          check("hold_valid", int'(tx_valid), 1);
          check("hold_data", int'(tx_data), int'(p_d));
        end
        if (fifo_rd_en) begin
          check("rd_b2b", int'(p_rd), 0);
          check("rd_empty", int'(fifo_empty), 0);
        end
        if (tx_valid && tx_ready && m_busy && !m_done) begin
          if (m_idx == 0) m_exp = 8'hAA;
          else if (m_idx == 1) m_exp = 8'h55;
          else if (m_idx == 2) m_exp = 8'(L >> 8);
          else if (m_idx == 3) m_exp = 8'(L & 255);
          else if (m_idx < 4 + L) begin
            check("sample_avail", int'(mdl_q.size() > 0), 1);
            m_exp = (mdl_q.size() > 0) ? mdl_q.pop_front() : 8'h00;
            m_csum = m_csum + m_exp;
          end else begin
            m_exp = m_csum;
            m_next_done = 1'b1;
          end
          check($sformatf("byte%0d", m_idx), int'(tx_data), int'(m_exp));
          log_q.push_back(tx_data);
          m_idx++;
        end
        if (m_done) begin
          m_done = 1'b0; m_busy = 1'b0; done_cnt++;
        end else if (m_next_done) begin
          m_done = 1'b1;
        end else if (!m_busy && fifo_full && !m_full_prev) begin
          m_busy = 1'b1; m_idx = 0; m_csum = 8'h00;
        end
        m_full_prev = fifo_full;
        p_v = tx_valid; p_r = tx_ready; p_d = tx_data; p_rd = fifo_rd_en;
      end
    end
  end

  // ---------------- Stimulus helpers
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input byte unsigned b);
    fifo_q.push_back(b);
    mdl_q.push_back(b);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check({nm, "_done"}, int'(done_cnt != start), 1);
  endtask

  task automatic check_log(input string nm, input logic [71:0] exp);
    check({nm, "_len"}, log_q.size(), 9);
    for (int i = 0; i < 9 && i < log_q.size(); i++)
      check($sformatf("%s_b%0d", nm, i), int'(log_q[i]), int'(exp[71-8*i -: 8]));
  endtask

  task automatic start_frame();
    fifo_full = 1'b1;
    tick(2);
    fifo_full = 1'b0;
  endtask

  // ---------------- Main sequence
  int pre;
  int d0;

  initial begin
    tick(3);
    check("rst_rd", int'(fifo_rd_en), 0);
    check("rst_valid", int'(tx_valid), 0);
    check("rst_data", int'(tx_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(frame_done), 0);
    rst_n = 1'b1;
    tick(3);

    // Basic frame, ready held high, latency and frame length pinned
    ready_fixed = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    tick(2);
    log_q.delete();
    busy_cycles = 0;
    fifo_full = 1'b1;
    tick();
    check("start_valid", int'(tx_valid), 1);
    check("start_data", int'(tx_data), 8'hAA);
    tick();
    fifo_full = 1'b0;
    wait_done("basic", 200);
    tick(2);
    check("basic_busy_cycles", busy_cycles, 4 + 3 * L + 2);
    check("basic_busy_end", int'(busy), 0);
    check_log("basic", 72'hAA_55_00_04_01_02_03_04_0A);

    // Backpressure: same stream under random ready
    rand_ready = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    tick(2);
    log_q.delete();
    start_frame();
    wait_done("bp", 400);
    check_log("bp", 72'hAA_55_00_04_01_02_03_04_0A);
    rand_ready = 1'b0;
    tick(2);

    // Empty stall mid-frame
    push(8'h10); push(8'h20);
    tick(2);
    log_q.delete();
    start_frame();
    tick(20);
    check("stall_busy", int'(busy), 1);
    check("stall_sent", log_q.size(), 6);
    push(8'h30); push(8'h40);
    wait_done("stall", 200);
    check_log("stall", 72'hAA_55_00_04_10_20_30_40_A0);
    tick(2);

    // Checksum wrap
    push(8'hFF); push(8'hFF); push(8'h03); push(8'h00);
    tick(2);
    log_q.delete();
    start_frame();
    wait_done("wrap", 200);
    check_log("wrap", 72'hAA_55_00_04_FF_FF_03_00_01);
    tick(2);

    // Reset during the sample phase, then fifo_full held across release
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick(2);
    d0 = done_cnt;
    start_frame();
    tick(6);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rd", int'(fifo_rd_en), 0);
    check("arst_valid", int'(tx_valid), 0);
    check("arst_data", int'(tx_data), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(frame_done), 0);
    fifo_q.delete();
    mdl_q.delete();
    fifo_full = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("full_held_busy", int'(busy), 0);
    check("no_done_after_rst", done_cnt, d0);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    fifo_full = 1'b0;
    tick(2);
    log_q.delete();
    start_frame();
    wait_done("restart", 200);
    check_log("restart", 72'hAA_55_00_04_11_22_33_44_AA);
    tick(2);

    // Randomized frames: random data, ready, FIFO fill timing, spurious full pulses
    for (int f = 0; f < 10; f++) begin
      rand_ready = ($urandom_range(0, 2) != 0);
      pre = $urandom_range(0, L);
      for (int k = 0; k < pre; k++) push(8'($urandom));
      tick(2);
      start_frame();
      for (int k = pre; k < L; k++) begin
        tick($urandom_range(1, 12));
        push(8'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          fifo_full = 1'b1;
          tick();
          fifo_full = 1'b0;
        end
      end
      wait_done("rand", 600);
      tick($urandom_range(1, 4));
    end
    rand_ready = 1'b0;
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
